// File: rtl/sample_history_delay_if.sv
// Stream bundle for sample_history_delay: accepted-sample input side and
// one-cycle-later history/difference output side.
interface sample_history_delay_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 1,
  parameter int AW       = 4
);
  logic                            in_valid;
  logic [CHANNELS*WIDTH-1:0]       in_data;
  logic [AW-1:0]                   delay;
  logic                            out_valid;
  logic [CHANNELS*WIDTH-1:0]       out_prev;
  logic [CHANNELS*(WIDTH+1)-1:0]   out_diff;
  logic                            primed;

  modport master (
    output in_valid, in_data, delay,
    input  out_valid, out_prev, out_diff, primed
  );

  modport slave (
    input  in_valid, in_data, delay,
    output out_valid, out_prev, out_diff, primed
  );
endinterface

// File: rtl/sample_history_delay.sv
// Per-lane ring-buffer history: for each accepted sample, returns the sample
// accepted `delay` valid-samples earlier plus the widened difference cur - prev.
module sample_history_delay #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 1,
  parameter int AW       = $clog2(DEPTH+1)
) (
  input logic                 clk,
  input logic                 reset,
  sample_history_delay_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = CHANNELS*WIDTH;
  localparam int DW = CHANNELS*(WIDTH+1);

  // Requested delay forced into the legal 1..DEPTH window.
  function automatic logic [AW-1:0] clamp_delay(input logic [AW-1:0] d);
    if (d == '0) return AW'(1);
    if (d > AW'(DEPTH)) return AW'(DEPTH);
    return d;
  endfunction

  // Ring index `back` entries behind ptr; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ring_back(input logic [PW-1:0] ptr,
                                              input logic [AW-1:0] back);
    logic [AW:0] p;
    logic [AW:0] b;
    p = (AW+1)'(ptr);
    b = (AW+1)'(back);
    if (p >= b) return PW'(p - b);
    return PW'(p + (AW+1)'(DEPTH) - b);
  endfunction

  function automatic logic signed [WIDTH:0] sub_ext(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] ae;
    logic signed [WIDTH:0] be;
    ae = a;
    be = b;
    return ae - be;
  endfunction

  logic [LW-1:0] ring [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] fill;
  logic [AW-1:0] d_reg;

  logic [AW-1:0] eff_p0;
  logic          same_p0;
  logic [PW-1:0] rd_idx_p0;
  logic [PW-1:0] wr_ptr_nxt;
  logic [AW-1:0] fill_nxt;
  logic          primed_p0;
  logic [LW-1:0] prev_p0;
  logic [DW-1:0] diff_p0;

  logic          vld_p1;
  logic          primed_p1;
  logic [LW-1:0] prev_p1;
  logic [DW-1:0] diff_p1;

  // ---- stage p0: clamp, ring read (before this cycle's write), history qualification
  always_comb begin
    eff_p0     = clamp_delay(bus.delay);
    same_p0    = (eff_p0 == d_reg);
    rd_idx_p0  = ring_back(wr_ptr, eff_p0);
    primed_p0  = same_p0 && (fill >= eff_p0);
    prev_p0    = primed_p0 ? ring[rd_idx_p0] : '0;
    wr_ptr_nxt = (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
    if (!same_p0)
      fill_nxt = AW'(1);
    else if (fill >= AW'(DEPTH))
      fill_nxt = fill;
    else
      fill_nxt = fill + AW'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic signed [WIDTH-1:0] cur_p0;
    logic signed [WIDTH-1:0] old_p0;
    assign cur_p0 = $signed(bus.in_data[i*WIDTH +: WIDTH]);
    assign old_p0 = $signed(prev_p0[i*WIDTH +: WIDTH]);
    assign diff_p0[i*(WIDTH+1) +: WIDTH+1] = sub_ext(cur_p0, old_p0);
  end

  // ---- stage p1: registered outputs and pointer/fill bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      primed_p1 <= 1'b0;
      prev_p1   <= '0;
      diff_p1   <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      d_reg     <= AW'(1);
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        primed_p1 <= primed_p0;
        prev_p1   <= prev_p0;
        diff_p1   <= diff_p0;
        wr_ptr    <= wr_ptr_nxt;
        fill      <= fill_nxt;
        d_reg     <= eff_p0;
      end
    end
  end

  // Ring storage is left unreset; stale entries are hidden by fill.
  always_ff @(posedge clk) begin
    if (bus.in_valid && !reset)
      ring[wr_ptr] <= bus.in_data;
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_prev  = prev_p1;
  assign bus.out_diff  = diff_p1;
  assign bus.primed    = primed_p1;

endmodule

// File: tb/tb_sample_history_delay.sv
// Directed bench for sample_history_delay: a 1-lane and a 3-lane instance share
// control; expectations are queued at issue time and popped by a negedge monitor.
module tb_sample_history_delay;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 4;

  typedef struct packed {
    logic             primed;
    logic [2:0][3:0]  p;
    logic [2:0][4:0]  d;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sample_history_delay_if #(.WIDTH(WIDTH), .CHANNELS(1), .AW(AW)) bus1 ();
  sample_history_delay_if #(.WIDTH(WIDTH), .CHANNELS(3), .AW(AW)) bus3 ();

  sample_history_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(1), .AW(AW)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  sample_history_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(3), .AW(AW)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave));

  exp_t sb[$];
  exp_t cur = '0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rst_q = 1'b0;
  bit   vld_q = 1'b0;
  bit   started = 1'b0;

  function automatic void chk(string name, int lane, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s lane %0d: got %0d, expected %0d", name, lane, act, exp);
    end
  endfunction

  // What the DUT saw at the last active edge.
  always @(posedge clk) begin
    rst_q <= reset;
    vld_q <= bus1.in_valid && !reset;
    if (reset) started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid_c1", 0, int'(bus1.out_valid), int'(vld_q));
      chk("out_valid_c3", 0, int'(bus3.out_valid), int'(vld_q));
      if (rst_q) begin
        cur = '0;
      end else if (bus1.out_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard_underflow: got out_valid with no queued expectation, required none");
        end else begin
          cur = sb.pop_front();
        end
      end
      chk("primed_c1", 0, int'(bus1.primed), int'(cur.primed));
      chk("primed_c3", 0, int'(bus3.primed), int'(cur.primed));
      chk("prev_c1", 0, int'($signed(bus1.out_prev)), int'($signed(cur.p[0])));
      chk("diff_c1", 0, int'($signed(bus1.out_diff)), int'($signed(cur.d[0])));
      for (int k = 0; k < 3; k++) begin
        chk("prev_c3", k, int'($signed(bus3.out_prev[k*4 +: 4])), int'($signed(cur.p[k])));
        chk("diff_c3", k, int'($signed(bus3.out_diff[k*5 +: 5])), int'($signed(cur.d[k])));
      end
    end
  end

  // Lane 0 carries `data`; lane 1 its bitwise inverse; lane 2 data ^ 5.
  // eprev/eprim are the hand-computed lane-0 history for this sample.
  task automatic step(input bit r, input bit v, input int dl, input int data,
                      input int eprev, input bit eprim);
    logic signed [3:0] x0, x1, x2, e0, q0, q1, q2;
    exp_t e;
    x0 = 4'(data);
    x1 = ~x0;
    x2 = x0 ^ 4'sb0101;
    e0 = 4'(eprev);
    if (eprim) begin
      q0 = e0;
      q1 = ~e0;
      q2 = e0 ^ 4'sb0101;
    end else begin
      q0 = '0;
      q1 = '0;
      q2 = '0;
    end
    e.primed = eprim;
    e.p[0] = q0;
    e.p[1] = q1;
    e.p[2] = q2;
    e.d[0] = 5'(int'(x0) - int'(q0));
    e.d[1] = 5'(int'(x1) - int'(q1));
    e.d[2] = 5'(int'(x2) - int'(q2));
    reset         = r;
    bus1.in_valid = v;
    bus3.in_valid = v;
    bus1.delay    = 4'(dl);
    bus3.delay    = 4'(dl);
    bus1.in_data  = x0;
    bus3.in_data  = {x2, x1, x0};
    if (v && !r) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int dl);
    step(1'b0, 1'b0, dl, 0, 0, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b0, 1, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1, 0, 0, 1'b0);

    // delay 1 ramp, then full-scale swings for the widened difference
    step(1'b0, 1'b1, 1,  1,  0, 1'b0);
    step(1'b0, 1'b1, 1,  2,  1, 1'b1);
    step(1'b0, 1'b1, 1,  3,  2, 1'b1);
    step(1'b0, 1'b1, 1, -8,  3, 1'b1);
    step(1'b0, 1'b1, 1,  7, -8, 1'b1);
    step(1'b0, 1'b1, 1, -8,  7, 1'b1);

    // delay = DEPTH: primes on the 9th sample, reads the slot about to be overwritten
    step(1'b1, 1'b0, 1, 0, 0, 1'b0);
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, 8, i, (i >= 8) ? i - 8 : 0, i >= 8);
    step(1'b0, 1'b1, 15, 12, 4, 1'b1);

    // sparse valids; delay wiggles on idle cycles must be ignored
    step(1'b1, 1'b0, 1, 0, 0, 1'b0);
    step(1'b0, 1'b1, 2,  5, 0, 1'b0);
    idle(7); idle(7);
    step(1'b0, 1'b1, 2,  6, 0, 1'b0);
    idle(7); idle(7);
    step(1'b0, 1'b1, 2,  7, 5, 1'b1);
    idle(7); idle(7);
    step(1'b0, 1'b1, 2, -1, 6, 1'b1);
    idle(7); idle(7);

    // delay 0 acts as 1, then change to 3 re-primes after three samples
    step(1'b0, 1'b1, 0, 1, 0, 1'b0);
    step(1'b0, 1'b1, 1, 2, 1, 1'b1);
    step(1'b0, 1'b1, 0, 3, 2, 1'b1);
    step(1'b0, 1'b1, 3, 4, 0, 1'b0);
    step(1'b0, 1'b1, 3, 5, 0, 1'b0);
    step(1'b0, 1'b1, 3, 6, 0, 1'b0);
    step(1'b0, 1'b1, 3, 7, 4, 1'b1);
    step(1'b0, 1'b1, 3, 1, 5, 1'b1);

    // reset wins over a simultaneous sample
    step(1'b1, 1'b1, 1, 6, 0, 1'b0);
    step(1'b0, 1'b1, 1, 2, 0, 1'b0);
    step(1'b0, 1'b1, 1, 3, 2, 1'b1);
    step(1'b0, 1'b1, 1, -5, 3, 1'b1);
    idle(1); idle(1); idle(1);

    chk("sb_drained", 0, sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
